// File: rtl/pixel_writer.sv
// Final rasterizer stage. It deserialises the PX/PY/C pixel streams and drops background and
// off-screen pixels. Visible pixels are queued as framebuffer writes; DONE is raised when a
// triangle has drained.
module pixel_writer #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned FRAC   = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_start,
  input  logic        s_valid,
  input  logic        px,
  input  logic        py,
  input  logic        c,
  input  logic        tri_done,
  output logic [16:0] fb_addr,
  output logic [15:0] fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        done,
  output logic        drop,
  output logic        ovf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned IntW = 16 - FRAC;
  localparam logic [IntW-1:0] XLim = IntW'(WIDTH);
  localparam logic [IntW-1:0] YLim = IntW'(HEIGHT);

  typedef enum logic [1:0] {StIdle, StPend, StDone} state_e;

  // Constant multiply by WIDTH unrolled into shift-adds (320 -> y<<8 + y<<6).
  function automatic logic [16:0] lin_addr(input logic [IntW-1:0] y, input logic [IntW-1:0] x);
    logic [16:0] acc;
    acc = 17'(x);
    for (int i = 0; i < 17; i++) begin
      if (WIDTH[i]) acc = acc + (17'(y) << i);
    end
    return acc;
  endfunction

  logic [14:0] sx_q, sx_d, sy_q, sy_d, sc_q, sc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        word_done;

  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d, fifo_cnt;
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic          empty, full, pop, push, push_req, lost, drained;
  logic          drop_q, drop_d, ovf_q, ovf_d;

  state_e state_q, state_d;
  logic   busy, can_finish;

  logic [15:0]     word_x, word_y, word_c;
  logic [IntW-1:0] x_int, y_int;
  logic            on_screen;

  // Deserialiser: cnt_q counts bits still to come; the cycle with cnt_q == 1 carries bit 0.
  always_comb begin
    sx_d      = sx_q;
    sy_d      = sy_q;
    sc_d      = sc_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    word_done = 1'b0;
    if (s_start) begin
      sx_d    = {14'b0, px};
      sy_d    = {14'b0, py};
      sc_d    = {14'b0, c};
      valid_d = s_valid;
      cnt_d   = 4'd15;
    end else if (cnt_q != 4'd0) begin
      sx_d      = {sx_q[13:0], px};
      sy_d      = {sy_q[13:0], py};
      sc_d      = {sc_q[13:0], c};
      cnt_d     = cnt_q - 4'd1;
      word_done = (cnt_q == 4'd1);
    end
  end

  assign word_x    = {sx_q, px};
  assign word_y    = {sy_q, py};
  assign word_c    = {sc_q, c};
  assign x_int     = word_x[15:FRAC];
  assign y_int     = word_y[15:FRAC];
  assign on_screen = !x_int[IntW-1] && !y_int[IntW-1] && (x_int < XLim) && (y_int < YLim);

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign fifo_cnt = wptr_q - rptr_q;
  assign fb_we    = !empty;
  assign {fb_addr, fb_data} = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    pop      = fb_we && fb_ready;
    push_req = word_done && valid_q && on_screen;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push     = push_req && (!full || pop);
    lost     = push_req && full && !pop;
    drop_d   = (word_done && valid_q && !on_screen) || lost;
    ovf_d    = ovf_q || lost;
    wptr_d   = wptr_q + (PtrW + 1)'(push);
    rptr_d   = rptr_q + (PtrW + 1)'(pop);
    drained  = empty || ((fifo_cnt == (PtrW + 1)'(1)) && pop);
    mem_d    = mem_q;
    if (push) mem_d[wptr_q[PtrW-1:0]] = {lin_addr(y_int, x_int), word_c};
  end

  assign busy       = s_start || (cnt_q != 4'd0);
  assign can_finish = !busy && drained && !push;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (tri_done) state_d = can_finish ? StDone : StPend;
        else          state_d = StIdle;
      end
      StPend:  if (can_finish) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  assign done = (state_q == StDone);
  assign drop = drop_q;
  assign ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      sc_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= StIdle;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sc_q    <= sc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
